vga_timing_gen: RTL
===================

# vga_timing_gen

Source end of the `vga_if` pixel stream: generates the raster position and sync/blanking signals that every downstream draw stage (background, platforms, player sprites) consumes and pipelines. Sits at the head of the video chain, driving `vga_out` into the first draw stage. Adds a frame-start strobe and a frame counter so game logic can update positions once per frame. The `rgb` field is driven black; all colour is added downstream.

## Interface

Parameters:
- `H_ACTIVE`, 800: visible pixels per line.
- `H_FP`, 40: horizontal front porch, in pixels.
- `H_SYNC`, 128: hsync width, in pixels.
- `H_BP`, 88: horizontal back porch; H_TOTAL = sum = 1056.
- `V_ACTIVE`, 600: visible lines.
- `V_FP`, 1: vertical front porch, in lines.
- `V_SYNC`, 4: vsync width, in lines.
- `V_BP`, 23: vertical back porch; V_TOTAL = sum = 628.
- `SYNC_POL`, 1: 1 = sync active-high; 0 = sync active-low.

Ports:
- `clk`  in  1  pixel-domain clock.
- `rst`  in  1  reset; synchronous, active-high.
- `pix_en`  in  1  pixel advance enable; tie to 1 for 1 pixel/clk at 40 MHz.
- `vga_out`  `vga_if.out`  —  `hcount[10:0]`, `vcount[10:0]`, `hsync`, `vsync`, `hblnk`, `vblnk`, `rgb[11:0]`.
- `frame_start`  out  1  one-clk pulse when the raster returns to (0,0).
- `frame_cnt`  out  16  completed-frame counter.

## Operation

- Internal counters `h` (0..H_TOTAL-1) and `v` (0..V_TOTAL-1).
- All outputs are registered and derived from the same next-position value, so every field is mutually consistent in each cycle. No combinational path from input to output.
- Advance rule, on a clk edge with `pix_en`=1:
  - h < H_TOTAL-1: h+1.
  - h = H_TOTAL-1: h→0; v→v+1, or v→0 if v = V_TOTAL-1.
- `pix_en`=0: every output holds its value; `frame_start` is 0.
- Derived signals, as a function of the output position:
  - `hblnk` = (hcount ≥ H_ACTIVE).
  - `hsync` active for H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC. Defaults: 840..967.
  - `vblnk` = (vcount ≥ V_ACTIVE).
  - `vsync` active for V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC. Defaults: 601..604.
  - Active level is set by `SYNC_POL`; the inactive level is its complement.
- Frame wrap is the advance from (H_TOTAL-1, V_TOTAL-1) to (0,0). In the cycle the outputs first show (0,0), `frame_start`=1. `frame_cnt` increments in that same cycle.
- `frame_cnt` wraps from 65535 to 0 with no flag.
- `rgb` is always 12'h000.
- Width rule: H_TOTAL and V_TOTAL must each be ≤ 2048. Parameter checks are elaboration-time assertions.

## Timing

- Reset values, on the first clk after `rst` is sampled high and for as long as it is held:
  - `hcount`=0, `vcount`=0, `frame_cnt`=0.
  - `frame_start`=0, `hblnk`=0, `vblnk`=0, `rgb`=0.
  - `hsync` and `vsync` at their inactive level.
- The reset-exit position (0,0) does not assert `frame_start`; only a wrap does.
- Reset mid-frame: the raster restarts from (0,0) and `frame_cnt` returns to 0. No partial-frame pulse is generated.
- `rst` has priority over `pix_en`.
- Latency: position changes one clk after `pix_en` is sampled high. Sync and blank signals change in the same cycle as the count that defines them; downstream stages delay all fields equally.
- Line period is H_TOTAL enabled cycles; frame period is H_TOTAL×V_TOTAL enabled cycles. Defaults: 1056 and 663 168.

## Test plan

- Reset: assert `rst` for 3 clk with `pix_en`=1, then release.
  - During reset: hcount=vcount=0, hsync=vsync=0 (`SYNC_POL`=1), blanks=0, `frame_cnt`=0.
  - hcount=1 one clk after release.
- Line scan with default params:
  - `hblnk` rises at hcount=800.
  - `hsync` is high for hcount 840..967, exactly 128 clk.
  - After hcount=1055 the next value is hcount=0 with vcount+1.
- Frame wrap: run 663 168 enabled clk from reset.
  - vsync is high for vcount 601..604, and `vblnk` is high from vcount 600.
  - At (0,0): `frame_start` is one clk wide and `frame_cnt`=1.
  - After 2 frames, `frame_cnt`=2.
- Stall: drop `pix_en` for 5 clk at hcount=967 (last hsync pixel).
  - All outputs hold and `frame_start`=0.
  - Resuming gives hcount=968 with hsync low.
  - Also stall across the frame wrap: `frame_start` fires exactly once.
- Reset mid-frame: assert `rst` at (500,300) with `frame_cnt`=3.
  - Next clk: (0,0) and `frame_cnt`=0, with no `frame_start` pulse.
- Reduced parameters (H 8/2/2/2, V 4/1/1/1, `SYNC_POL`=0):
  - Full frame is 14×7 = 98 clk.
  - `hsync` is low for hcount 10..11; `vsync` is low for vcount 5.
  - `frame_cnt` is forced to 65535 before a wrap and reads 0 after it.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster position and sync/blank bundle passed down the video draw chain.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counter and sync/blank generator at the head of the video chain.
// One clk from pix_en to new position; pix_en low freezes every output.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int SYNC_POL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  vga_if.out          vga_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("H_TOTAL must not exceed 2048");
  end
  if (V_TOTAL > 2048) begin : g_v_total_chk
    $error("V_TOTAL must not exceed 2048");
  end

  // Compare in 12 bits so a sync window ending exactly at 2048 stays representable.
  localparam logic [11:0] HB_BEG = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VB_BEG = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic        SP     = (SYNC_POL != 0);

  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic        wrap;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        fs_q;
  logic [15:0] frame_cnt_q;
  logic [11:0] h_ext, v_ext;

  always_comb begin
    h_d  = h_q;
    v_d  = v_q;
    wrap = 1'b0;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = 11'd0;
        if (v_q == V_LAST) begin
          v_d  = 11'd0;
          wrap = 1'b1;
        end else begin
          v_d = v_q + 11'd1;
        end
      end else begin
        h_d = h_q + 11'd1;
      end
    end
  end

  // Sync/blank decode from the next position so they register alongside the counts.
  always_comb begin
    h_ext   = {1'b0, h_d};
    v_ext   = {1'b0, v_d};
    hblnk_d = (h_ext >= HB_BEG);
    vblnk_d = (v_ext >= VB_BEG);
    hsync_d = ((h_ext >= HS_BEG) && (h_ext < HS_END)) == SP;
    vsync_d = ((v_ext >= VS_BEG) && (v_ext < VS_END)) == SP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q         <= 11'd0;
      v_q         <= 11'd0;
      hsync_q     <= ~SP;
      vsync_q     <= ~SP;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      fs_q        <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      hblnk_q <= hblnk_d;
      vblnk_q <= vblnk_d;
      fs_q    <= wrap;
      if (wrap) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign vga_out.hcount = h_q;
  assign vga_out.vcount = v_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = 12'h000;
  assign frame_start    = fs_q;
  assign frame_cnt      = frame_cnt_q;

endmodule
